// File: rtl/demux1a2_dosbits_fifo.sv
// 1:2 lane demux: accepted words alternate between lane 0 and lane 1, each lane buffered in a show-ahead FIFO.
// Optional macro DEMUX_DROP_CNT_EN adds a saturating 8-bit drop counter output (drop_cnt).

module demux1a2_lane_fifo #(
    parameter int DATA_W = 2,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push_i,
    input  logic              pop_i,
    input  logic [DATA_W-1:0] din_i,
    output logic              full_o,
    output logic              valid_o,
    output logic [DATA_W-1:0] dout_o
);
    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [AW:0]       count_q, count_d;
    logic              pop_eff;

    assign valid_o = (count_q != '0);
    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign dout_o  = valid_o ? mem_q[rd_ptr_q] : '0;
    // A pop on an empty lane is ignored, even if a push lands on the same edge.
    assign pop_eff = pop_i && valid_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_i)  wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop_eff) rd_ptr_d = rd_ptr_q + AW'(1);
        case ({push_i, pop_eff})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (push_i) mem_q[wr_ptr_q] <= din_i;
        end
    end
endmodule

module demux1a2_dosbits_fifo #(
    parameter int DATA_W = 2,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              valid_in,
    input  logic [DATA_W-1:0] data_in,
    output logic              ready_in,
    input  logic              pop0,
    input  logic              pop1,
    output logic              valid0,
    output logic              valid1,
    output logic [DATA_W-1:0] data_out0,
    output logic [DATA_W-1:0] data_out1,
    output logic              sel_q,
    output logic              overflow
`ifdef DEMUX_DROP_CNT_EN
    ,
    output logic [7:0]        drop_cnt
`endif
);
    localparam int NUM_LANES = 2;

    logic [NUM_LANES-1:0]             full, valid, push, pop;
    logic [NUM_LANES-1:0][DATA_W-1:0] dout;
    logic accept, drop, sel_d, overflow_q, overflow_d;

    // ready_in looks only at the current fill level; a same-cycle pop does not free a slot.
    assign ready_in = !full[sel_q];
    assign accept   = valid_in && ready_in;
    assign drop     = valid_in && !ready_in;
    assign pop      = {pop1, pop0};

    always_comb begin
        push         = '0;
        push[sel_q]  = accept;
        sel_d        = sel_q ^ accept;
        overflow_d   = overflow_q | drop;
    end

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        demux1a2_lane_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
            .clk     (clk),
            .reset   (reset),
            .push_i  (push[g]),
            .pop_i   (pop[g]),
            .din_i   (data_in),
            .full_o  (full[g]),
            .valid_o (valid[g]),
            .dout_o  (dout[g])
        );
    end

    assign valid0    = valid[0];
    assign valid1    = valid[1];
    assign data_out0 = dout[0];
    assign data_out1 = dout[1];
    assign overflow  = overflow_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sel_q      <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            sel_q      <= sel_d;
            overflow_q <= overflow_d;
        end
    end

`ifdef DEMUX_DROP_CNT_EN
    logic [7:0] drop_cnt_q, drop_cnt_d;

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (drop && drop_cnt_q != 8'hFF) drop_cnt_d = drop_cnt_q + 8'd1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) drop_cnt_q <= 8'd0;
        else       drop_cnt_q <= drop_cnt_d;
    end

    assign drop_cnt = drop_cnt_q;
`endif
endmodule

// File: doc/demux1a2_dosbits_fifo.md
Name: demux1a2_dosbits_fifo

Overview:
- 1-to-2 demultiplexer for the 2-bit valid/data lane; the inverse of the 2:1 lane mux.
- Accepts one serial stream (valid_in/data_in) and distributes accepted words alternately to lane 0 and lane 1, starting with lane 0.
- Each lane is buffered in its own show-ahead FIFO and drained by a downstream pop.
- Sits at the receive end of the interleaved 2-bit link, feeding the per-lane consumers.

Parameters:
- DATA_W, 2: lane data width in bits.
- DEPTH, 4: entries per lane FIFO; power of 2, minimum 2.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- valid_in  input  1  input word present this cycle.
- data_in  input  DATA_W  input word.
- ready_in  output  1  FIFO of the current target lane is not full.
- pop0  input  1  consumer 0 removes the lane-0 head.
- pop1  input  1  consumer 1 removes the lane-1 head.
- valid0  output  1  lane-0 FIFO non-empty.
- valid1  output  1  lane-1 FIFO non-empty.
- data_out0  output  DATA_W  lane-0 head word; 0 when empty.
- data_out1  output  DATA_W  lane-1 head word; 0 when empty.
- sel_q  output  1  current target lane for the next accepted word.
- overflow  output  1  sticky flag: a word was dropped.

Behaviour:
- Reset (async, active-high) clears all state immediately, including when asserted mid-transfer. After reset:
  - sel_q=0, overflow=0, both FIFOs empty.
  - valid0=valid1=0, data_out0=data_out1=0.
  - ready_in=1, and all pointers and counts are 0.
- Accept: valid_in=1 and the target FIFO (selected by sel_q) is not full.
  - data_in is written to the target lane's tail on that rising edge.
  - sel_q toggles on the same edge.
- Drop: valid_in=1 and the target FIFO is full.
  - The word is discarded, sel_q does NOT toggle, and overflow is set (sticky until reset).
- valid_in=0: no write, sel_q holds.
- ready_in is combinational: !full(target lane). It does not depend on a pop in the same cycle, so there is no same-cycle bypass when full.
- Show-ahead read path:
  - validN = (countN != 0).
  - data_outN = mem[rd_ptrN] when non-empty, else 0.
  - A word becomes visible one cycle after it is accepted (write-to-valid latency is 1 clk).
- Pop:
  - popN=1 with validN=1 advances rd_ptrN and decrements countN on the edge.
  - popN=1 with validN=0 is ignored; there is no underflow and no state change.
- Simultaneous push and pop on the same lane, not full: both occur and the count is unchanged.
  - On an empty lane, push plus pop results in the pushed word being stored; the pop is ignored because the lane was empty.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH.
- countN ranges 0..DEPTH inclusive (log2(DEPTH)+1 bits). Full means countN==DEPTH.
- Lanes are independent: a full lane 1 does not block lane 0 pops, and vice versa.

Optional Feature:
- Macro: DEMUX_DROP_CNT_EN.
- Defined:
  - Adds output port drop_cnt [7:0].
  - Increments on every dropped word and saturates at 8'hFF; reset clears it to 0.
  - overflow behaves as above.
- Undefined:
  - The drop_cnt port and counter do not exist.
  - overflow is the only drop indication.

Test Plan:
- Reset, then valid_in=1 with data_in 2'b01, 2'b10, 2'b11, 2'b00 on 4 consecutive cycles:
  - -> lane0 holds 01, 11 and lane1 holds 10, 00.
  - -> valid0/valid1 rise one cycle after the first and second accepts respectively.
  - -> sel_q ends at 0.
- No pops, 8 accepted words (data 0,1,2,3,0,1,2,3):
  - -> both lanes full, and ready_in=0.
  - -> 9th word (data 2'b10) is dropped, sel_q stays 0, overflow=1.
  - -> with DEMUX_DROP_CNT_EN, drop_cnt=1.
- Lane0 full, pop0=1 and valid_in=1 to lane0 in the same cycle:
  - -> ready_in=0 in that cycle, so the word is dropped.
  - -> after the edge, count0=3 and ready_in=1.
- pop1=1 with lane1 empty for 3 cycles:
  - -> valid1 stays 0, data_out1=0, no state change.
- Lane1 holding 2 words, assert reset asynchronously between clock edges:
  - -> valid1=0, data_out1=0, sel_q=0, overflow=0 immediately, without waiting for a clock edge.
- Continuous stream of 12 words with pop0=pop1=1 every cycle:
  - -> no drops and overflow=0.
  - -> each lane outputs its words in order, confirming pointers wrap past DEPTH=4.
